// File: rtl/bus_cycle_ctrl_if.sv
// Bus-cycle controller signal bundle: CPU address/ready in, strobes, phi2 and region selects out.
// master = bus_cycle_ctrl side; slave = CPU/system side.
interface bus_cycle_ctrl_if;
  logic [15:0] addr;
  logic        ext_rdy;
  logic        cpu_clken;
  logic        per_clken;
  logic        phi2;
  logic        ram_e;
  logic        rom_e;
  logic        acia_e;
  logic        via_e;
  logic        bus_e;
  logic        bus_timeout;
  logic        fsm_state;   // 0 = RUN, 1 = STRETCH

  modport master (
    input  addr, ext_rdy,
    output cpu_clken, per_clken, phi2, ram_e, rom_e, acia_e, via_e, bus_e,
           bus_timeout, fsm_state
  );

  modport slave (
    output addr, ext_rdy,
    input  cpu_clken, per_clken, phi2, ram_e, rom_e, acia_e, via_e, bus_e,
           bus_timeout, fsm_state
  );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 65C02 bus-cycle sequencer: clock enables, phi2, address decode and per-region wait states.
// Optional ext_rdy hold with timeout is enabled by defining BUS_CYCLE_CTRL_EXT_RDY_EN.
module bus_cycle_ctrl #(
  parameter int CLKEN_BITS    = 2,
  parameter int RAM_ADDR_BITS = 15,
  parameter int ROM_ADDR_BITS = 14,
  parameter int EXT_WAIT      = 2,
  parameter int IO_WAIT       = 0,
  parameter int RDY_TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          resb,
  bus_cycle_ctrl_if.master bus
);

  typedef enum logic {RUN = 1'b0, STRETCH = 1'b1} state_t;

  localparam logic [16:0] RAM_TOP  = 17'(1 << RAM_ADDR_BITS);
  localparam logic [16:0] ROM_BASE = 17'(65536 - (1 << ROM_ADDR_BITS));

  state_t                  state, state_n;
  logic [CLKEN_BITS-1:0]   ctr, ctr_n;
  logic [3:0]              wcnt, wcnt_n, wait_load;
  logic                    cpu_clken_q, per_clken_q, phi2_q;
  logic                    strobe_n, terminal, hold;
  logic                    ram_sel, rom_sel, acia_sel, via_sel, bus_sel;

  // Decode is purely combinational so the selects track addr even in reset.
  assign ram_sel  = {1'b0, bus.addr} < RAM_TOP;
  assign rom_sel  = {1'b0, bus.addr} >= ROM_BASE;
  assign acia_sel = bus.addr[15:4] == 12'h800;
  assign via_sel  = bus.addr[15:4] == 12'h880;
  assign bus_sel  = ~(ram_sel | rom_sel | acia_sel | via_sel);

  assign wait_load = bus_sel              ? 4'(EXT_WAIT) :
                     (acia_sel | via_sel) ? 4'(IO_WAIT)  : 4'd0;

  assign terminal = &ctr;

`ifdef BUS_CYCLE_CTRL_EXT_RDY_EN
  logic       rdy_meta, rdy_sync, timeout_q;
  logic [7:0] hcnt;

  // Synchronizer resets to "ready" so no hold is seen right after reset.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      rdy_meta <= 1'b1;
      rdy_sync <= 1'b1;
    end else begin
      rdy_meta <= bus.ext_rdy;
      rdy_sync <= rdy_meta;
    end
  end

  assign hold = bus_sel & ~rdy_sync & (hcnt < 8'(RDY_TIMEOUT));

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      hcnt      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      if (cpu_clken_q)
        hcnt <= 8'd0;
      else if (terminal && wcnt == 4'd0 && hold)
        hcnt <= hcnt + 8'd1;
      // Hold wanted but the limit is reached: this terminal count releases it.
      if (terminal && wcnt == 4'd0 && bus_sel && !rdy_sync && !hold)
        timeout_q <= 1'b1;
    end
  end

  assign bus.bus_timeout = timeout_q;
`else
  logic unused_rdy;
  assign unused_rdy      = bus.ext_rdy;
  assign hold            = 1'b0;
  assign bus.bus_timeout = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    wcnt_n   = wcnt;
    strobe_n = 1'b0;
    ctr_n    = ctr + 1'b1;
    // per_clken sits at ctr=1, so a load never coincides with a terminal count.
    if (per_clken_q)
      wcnt_n = wait_load;
    if (terminal) begin
      if (wcnt != 4'd0) begin
        wcnt_n  = wcnt - 4'd1;
        state_n = STRETCH;
      end else if (hold) begin
        state_n = STRETCH;
      end else begin
        state_n  = RUN;
        strobe_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      state       <= RUN;
      ctr         <= '0;
      wcnt        <= 4'd0;
      cpu_clken_q <= 1'b0;
      per_clken_q <= 1'b0;
      phi2_q      <= 1'b0;
    end else begin
      state       <= state_n;
      ctr         <= ctr_n;
      wcnt        <= wcnt_n;
      cpu_clken_q <= strobe_n;
      per_clken_q <= cpu_clken_q;
      phi2_q      <= (state_n == STRETCH) | ctr_n[CLKEN_BITS-1];
    end
  end

  assign bus.cpu_clken = cpu_clken_q;
  assign bus.per_clken = per_clken_q;
  assign bus.phi2      = phi2_q;
  assign bus.ram_e     = ram_sel;
  assign bus.rom_e     = rom_sel;
  assign bus.acia_e    = acia_sel;
  assign bus.via_e     = via_sel;
  assign bus.bus_e     = bus_sel;
  assign bus.fsm_state = state;

endmodule
